// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: per-cycle advance/hold/bubble
// decisions for PC, IF/ID, ID/EX, EX/MEM plus fetch watchdog and event counters.
module hazard_ctrl #(
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned FETCH_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_ready,
  input  logic              dmem_busy,
  input  logic              branch_taken_ex,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  output logic              pc_en,
  output logic              pc_sel_branch,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_mem_en,
  output logic              mem_wb_flush,
  output logic [1:0]        ctrl_state,
  output logic              fetch_err,
  output logic [CNT_W-1:0]  cnt_stall,
  output logic [CNT_W-1:0]  cnt_flush,
  output logic [CNT_W-1:0]  cnt_freeze,
  output logic [CNT_W-1:0]  cnt_fwait
);

  localparam int unsigned WD_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(FETCH_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FWAIT  = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            load_use;
  logic            rule_freeze, rule_redirect, rule_stall, rule_fwait;
  logic [WD_W-1:0] wdog_q;

  // Load-use: the ID instruction needs a value the load in EX has not produced yet.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Priority chain, first match wins; reset forces the pipeline to fill with bubbles.
  always_comb begin
    state_d       = ST_RUN;
    pc_en         = 1'b1;
    pc_sel_branch = 1'b0;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_flush  = 1'b0;
    rule_freeze   = 1'b0;
    rule_redirect = 1'b0;
    rule_stall    = 1'b0;
    rule_fwait    = 1'b0;
    if (reset) begin
      pc_en        = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (dmem_busy) begin
      rule_freeze  = 1'b1;
      state_d      = ST_FREEZE;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (branch_taken_ex) begin
      rule_redirect = 1'b1;
      pc_sel_branch = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end else if (load_use) begin
      rule_stall  = 1'b1;
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (!imem_ready) begin
      rule_fwait  = 1'b1;
      state_d     = ST_FWAIT;
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  assign ctrl_state = state_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != '1)) sat_inc = v + CNT_W'(1);
    else                  sat_inc = v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_stall  <= '0;
      cnt_flush  <= '0;
      cnt_freeze <= '0;
      cnt_fwait  <= '0;
    end else begin
      cnt_stall  <= sat_inc(cnt_stall,  rule_stall);
      cnt_flush  <= sat_inc(cnt_flush,  rule_redirect);
      cnt_freeze <= sat_inc(cnt_freeze, rule_freeze);
      cnt_fwait  <= sat_inc(cnt_fwait,  rule_fwait);
    end
  end

  // Watchdog counts an unbroken run of fetch waits; fetch_err is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q    <= '0;
      fetch_err <= 1'b0;
    end else if (rule_fwait) begin
      if (wdog_q != WD_MAX) wdog_q <= wdog_q + WD_W'(1);
      if (wdog_q >= WD_LAST) fetch_err <= 1'b1;
    end else begin
      wdog_q <= '0;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; a second instance with 4-bit
// counters shares the stimulus to exercise counter saturation.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       imem_ready, dmem_busy, branch_taken_ex;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read;

  logic        pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_en, mem_wb_flush, fetch_err;
  logic [1:0]  ctrl_state;
  logic [15:0] cnt_stall, cnt_flush, cnt_freeze, cnt_fwait;

  logic        s_pc_en, s_pc_sel_branch, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush;
  logic        s_ex_mem_en, s_mem_wb_flush, s_fetch_err;
  logic [1:0]  s_ctrl_state;
  logic [3:0]  s_cnt_stall, s_cnt_flush, s_cnt_freeze, s_cnt_fwait;

  int n_checks = 0;
  int n_errors = 0;

  // Control vector order: pc_en pc_sel if_id_en if_id_flush id_ex_en id_ex_flush ex_mem_en mem_wb_flush
  localparam logic [7:0] C_RESET  = 8'b0011_1111;
  localparam logic [7:0] C_RUN    = 8'b1010_1010;
  localparam logic [7:0] C_FREEZE = 8'b0000_0001;
  localparam logic [7:0] C_REDIR  = 8'b1111_1110;
  localparam logic [7:0] C_STALL  = 8'b0000_1110;
  localparam logic [7:0] C_FWAIT  = 8'b0011_1010;

  logic [7:0] ctl;
  assign ctl = {pc_en, pc_sel_branch, if_id_en, if_id_flush,
                id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};

  hazard_ctrl #(.REG_AW(5), .CNT_W(16), .FETCH_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .branch_taken_ex(branch_taken_ex), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .pc_en(pc_en), .pc_sel_branch(pc_sel_branch),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
    .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_flush(mem_wb_flush),
    .ctrl_state(ctrl_state), .fetch_err(fetch_err), .cnt_stall(cnt_stall),
    .cnt_flush(cnt_flush), .cnt_freeze(cnt_freeze), .cnt_fwait(cnt_fwait)
  );

  hazard_ctrl #(.REG_AW(5), .CNT_W(4), .FETCH_TIMEOUT(64)) dut_small (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .branch_taken_ex(branch_taken_ex), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .pc_en(s_pc_en), .pc_sel_branch(s_pc_sel_branch),
    .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush), .id_ex_en(s_id_ex_en),
    .id_ex_flush(s_id_ex_flush), .ex_mem_en(s_ex_mem_en), .mem_wb_flush(s_mem_wb_flush),
    .ctrl_state(s_ctrl_state), .fetch_err(s_fetch_err), .cnt_stall(s_cnt_stall),
    .cnt_flush(s_cnt_flush), .cnt_freeze(s_cnt_freeze), .cnt_fwait(s_cnt_fwait)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; combinational outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    imem_ready = 1'b1; dmem_busy = 1'b0; branch_taken_ex = 1'b0;
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0;
  endtask

  task automatic hazard();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #1;
    check("reset_ctl", 32'(ctl), 32'(C_RESET));
    tick();
    check("reset_state", 32'(ctrl_state), 0);
    check("reset_cnts", {cnt_stall, cnt_flush}, 0);
    check("reset_ferr", 32'(fetch_err), 0);
    reset = 1'b0;
    #1;
    check("run_ctl", 32'(ctl), 32'(C_RUN));

    // Load-use via rs1, then rd==x0, then via rs2, then with no source use.
    hazard(); #1;
    check("lu_ctl", 32'(ctl), 32'(C_STALL));
    tick();
    check("lu_cnt", 32'(cnt_stall), 1);
    ex_rd = 5'd0; id_rs1 = 5'd0; #1;
    check("lu_x0_ctl", 32'(ctl), 32'(C_RUN));
    tick();
    check("lu_x0_cnt", 32'(cnt_stall), 1);
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1; #1;
    check("lu_rs2_ctl", 32'(ctl), 32'(C_STALL));
    tick();
    id_uses_rs2 = 1'b0; #1;
    check("lu_nouse_ctl", 32'(ctl), 32'(C_RUN));
    tick();
    check("lu_rs2_cnt", 32'(cnt_stall), 2);

    // Branch wins over load-use.
    do_reset();
    hazard(); branch_taken_ex = 1'b1; #1;
    check("br_lu_ctl", 32'(ctl), 32'(C_REDIR));
    tick();
    check("br_lu_flush", 32'(cnt_flush), 1);
    check("br_lu_stall", 32'(cnt_stall), 0);

    // Freeze for three cycles holding a branch, then redirect.
    do_reset();
    dmem_busy = 1'b1; branch_taken_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("frz_ctl", 32'(ctl), 32'(C_FREEZE));
      tick();
      check("frz_state", 32'(ctrl_state), 2);
    end
    dmem_busy = 1'b0; #1;
    check("frz_exit_ctl", 32'(ctl), 32'(C_REDIR));
    tick();
    check("frz_exit_state", 32'(ctrl_state), 0);
    check("frz_cnt", 32'(cnt_freeze), 3);
    check("frz_flush", 32'(cnt_flush), 1);

    // Fetch wait up to the timeout; fetch_err is sticky.
    do_reset();
    imem_ready = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      #1;
      check("fw_ctl", 32'(ctl), 32'(C_FWAIT));
      tick();
      if (i == 63) check("fw_err_63", 32'(fetch_err), 0);
    end
    check("fw_err_64", 32'(fetch_err), 1);
    check("fw_state", 32'(ctrl_state), 1);
    check("fw_cnt", 32'(cnt_fwait), 64);
    check("fw_sat_small", 32'(s_cnt_fwait), 15);
    imem_ready = 1'b1;
    tick(); tick();
    check("fw_err_hold", 32'(fetch_err), 1);
    check("fw_state_run", 32'(ctrl_state), 0);
    do_reset(); #1;
    check("fw_err_clr", 32'(fetch_err), 0);

    // A single ready cycle clears the watchdog run.
    imem_ready = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    imem_ready = 1'b1; tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check("wd_clear", 32'(fetch_err), 0);

    // Twenty load-use events saturate the 4-bit counter.
    do_reset();
    hazard();
    for (int i = 0; i < 20; i++) tick();
    check("sat_small", 32'(s_cnt_stall), 15);
    check("sat_wide", 32'(cnt_stall), 20);

    // Reset during freeze.
    do_reset();
    dmem_busy = 1'b1;
    tick(); tick();
    check("rf_state_pre", 32'(ctrl_state), 2);
    reset = 1'b1; #1;
    check("rf_ctl", 32'(ctl), 32'(C_RESET));
    tick();
    check("rf_state", 32'(ctrl_state), 0);
    check("rf_cnt", 32'(cnt_freeze), 0);
    reset = 1'b0; dmem_busy = 1'b0; #1;
    check("rf_run_ctl", 32'(ctl), 32'(C_RUN));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
